// File: rtl/seg7_scan_ctrl.sv
// Multiplexed N-digit 7-segment scan driver with frame-synchronous double buffering.
// Slot outputs are registered one clk behind the prescaler/index state; frame_done marks the commit cycle.
module seg7_scan_ctrl #(
  parameter int NUM_DIG        = 6,
  parameter int SCAN_DIV       = 1024,
  parameter int BLANK_CYC      = 16,
  parameter int SEL_ACTIVE_LOW = 1,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int LZB            = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   load,
  input  logic [4*NUM_DIG-1:0]   data_in,
  input  logic [NUM_DIG-1:0]     dp_in,
  input  logic [NUM_DIG-1:0]     blank_in,
  output logic [NUM_DIG-1:0]     sel,
  output logic [7:0]             dig,
  output logic                   frame_done
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(NUM_DIG);
  localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] BLANK_END = PW'(BLANK_CYC);
  localparam logic [IW-1:0] IDX_MAX   = IW'(NUM_DIG - 1);
  localparam logic [NUM_DIG-1:0] SEL_OFF = (SEL_ACTIVE_LOW != 0) ? {NUM_DIG{1'b1}} : {NUM_DIG{1'b0}};
  localparam logic [7:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

  logic [PW-1:0]        presc;
  logic [IW-1:0]        idx;
  logic [4*NUM_DIG-1:0] pend_data, shd_data;
  logic [NUM_DIG-1:0]   pend_dp, pend_blank, shd_dp, shd_blank;
  logic                 pend_v;
  logic                 boundary;

  logic [3:0]           cur_nib;
  logic                 cur_dp, cur_blank, lead_zero;
  logic [NUM_DIG-1:0]   sel_on;
  logic [7:0]           seg_low, dig_next;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;  4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;  4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;  4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;  4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
    endcase
  endfunction

  assign boundary   = en && (idx == IDX_MAX) && (presc == PRESC_MAX);
  assign frame_done = boundary;

  // Digit 0 is leftmost and lives in the top nibble/bit; lead_zero tracks "all digits so far are 0".
  always_comb begin
    cur_nib   = 4'h0;
    cur_dp    = 1'b0;
    cur_blank = 1'b1;
    lead_zero = 1'b1;
    sel_on    = SEL_OFF;
    for (int i = 0; i < NUM_DIG; i++) begin
      if (shd_data[4*(NUM_DIG-1-i) +: 4] != 4'h0) lead_zero = 1'b0;
      if (IW'(i) == idx) begin
        cur_nib   = shd_data[4*(NUM_DIG-1-i) +: 4];
        cur_dp    = shd_dp[NUM_DIG-1-i];
        cur_blank = shd_blank[NUM_DIG-1-i] | ((LZB != 0) && lead_zero && (i != NUM_DIG-1));
        sel_on[NUM_DIG-1-i] = ~SEL_OFF[NUM_DIG-1-i];
      end
    end
    seg_low  = cur_blank ? 8'hFF : {~cur_dp, hex7(cur_nib)};
    dig_next = (SEG_ACTIVE_LOW != 0) ? seg_low : ~seg_low;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc      <= '0;
      idx        <= '0;
      sel        <= SEL_OFF;
      dig        <= SEG_OFF;
      pend_data  <= '0;
      pend_dp    <= '0;
      pend_blank <= '1;
      pend_v     <= 1'b0;
      shd_data   <= '0;
      shd_dp     <= '0;
      shd_blank  <= '1;
    end else begin
      if (!en) begin
        presc <= '0;
        idx   <= '0;
        sel   <= SEL_OFF;
        dig   <= SEG_OFF;
      end else begin
        if (presc == PRESC_MAX) begin
          presc <= '0;
          idx   <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
        end else begin
          presc <= presc + 1'b1;
        end
        if (presc < BLANK_END) begin
          sel <= SEL_OFF;
          dig <= SEG_OFF;
        end else begin
          sel <= sel_on;
          dig <= dig_next;
        end
      end

      // A load landing on the commit cycle bypasses pending so it is not delayed a whole frame.
      if (load) begin
        if (boundary) begin
          shd_data  <= data_in;
          shd_dp    <= dp_in;
          shd_blank <= blank_in;
          pend_v    <= 1'b0;
        end else begin
          pend_data  <= data_in;
          pend_dp    <= dp_in;
          pend_blank <= blank_in;
          pend_v     <= 1'b1;
        end
      end else if (boundary && pend_v) begin
        shd_data  <= pend_data;
        shd_dp    <= pend_dp;
        shd_blank <= pend_blank;
        pend_v    <= 1'b0;
      end
    end
  end

endmodule
